// File: rtl/maze_mem.sv
// Maze storage responder for the solver's row/col/oe/we interface.
// Holds an N x N wall bitmap loaded row by row over a valid/ready port, serves
// registered single-cycle reads, tracks visited cells, counts distinct visits
// and flags writes aimed at wall cells.
module maze_mem #(
  parameter int N     = 64,
  parameter int IDX_W = 6,
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N-1:0]     load_data,
  input  logic             reload,
  output logic             loaded,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  input  logic             maze_oe,
  input  logic             maze_we,
  output logic             maze_in,
  output logic             maze_vis,
  output logic [CNT_W-1:0] path_count,
  output logic             err_wall_we
);

  typedef enum logic {LOAD, SERVE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] lr;

  // Storage arrays carry no reset: LOAD rewrites wall and clears visited per row.
  logic [N-1:0]     wall    [N];
  logic [N-1:0]     visited [N];

  logic             accept;
  logic             last_row;
  logic             restart;
  logic             serve_rd;
  logic             serve_wr;
  logic             cell_wall;
  logic             cell_vis;

  assign accept    = (state == LOAD) && load_valid;
  assign last_row  = (lr == IDX_W'(N - 1));
  // A reload cycle swallows any solver access issued alongside it.
  assign restart   = (state == SERVE) && reload;
  assign serve_rd  = (state == SERVE) && maze_oe && !reload;
  assign serve_wr  = (state == SERVE) && maze_we && !reload;
  // Pre-write view of the addressed cell; used by both read and write paths.
  assign cell_wall = wall[row][col];
  assign cell_vis  = visited[row][col];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic: leave LOAD on the last accepted row, leave SERVE on reload.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && last_row) state_nxt = SERVE;
      SERVE:   if (reload)             state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Port status decoded straight from the state.
  always_comb begin
    load_ready = 1'b0;
    loaded     = 1'b0;
    case (state)
      LOAD:    load_ready = 1'b1;
      SERVE:   loaded     = 1'b1;
      default: load_ready = 1'b1;
    endcase
  end

  // Load row counter; wraps to 0 after the last row and is forced to 0 on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lr <= '0;
    else if (restart) lr <= '0;
    else if (accept)  lr <= last_row ? '0 : lr + IDX_W'(1);
  end

  // Wall bitmap: written only while loading.
  always_ff @(posedge clk) begin
    if (accept) wall[lr] <= load_data;
  end

  // Visited bitmap: row cleared as it is loaded, cells set by legal solver writes.
  always_ff @(posedge clk) begin
    if (accept)                       visited[lr]       <= '0;
    else if (serve_wr && !cell_wall)  visited[row][col] <= 1'b1;
  end

  // Registered read port; holds its value whenever no read is served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maze_in  <= 1'b0;
      maze_vis <= 1'b0;
    end else if (serve_rd) begin
      maze_in  <= cell_wall;
      maze_vis <= cell_vis;
    end
  end

  // Distinct-visit counter (saturating) and sticky wall-write error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      path_count  <= '0;
      err_wall_we <= 1'b0;
    end else if (restart) begin
      path_count  <= '0;
      err_wall_we <= 1'b0;
    end else if (serve_wr) begin
      if (cell_wall)
        err_wall_we <= 1'b1;
      else if (!cell_vis && (path_count != {CNT_W{1'b1}}))
        path_count <= path_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_maze_mem.sv
// Scoreboard bench for maze_mem: stimulus pushes timestamped expectations,
// a negedge monitor pops and compares them when the DUT output is due.
module tb_maze_mem;

  localparam int N     = 64;
  localparam int IDX_W = 6;
  localparam int CNT_W = 13;

  localparam int K_RD  = 0;  // {maze_in, maze_vis}
  localparam int K_CNT = 1;  // path_count
  localparam int K_ERR = 2;  // err_wall_we
  localparam int K_LDD = 3;  // loaded
  localparam int K_RDY = 4;  // load_ready

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [N-1:0]     load_data;
  logic             reload;
  logic             loaded;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic             maze_oe;
  logic             maze_we;
  logic             maze_in;
  logic             maze_vis;
  logic [CNT_W-1:0] path_count;
  logic             err_wall_we;

  maze_mem #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .reload     (reload),
    .loaded     (loaded),
    .row        (row),
    .col        (col),
    .maze_oe    (maze_oe),
    .maze_we    (maze_we),
    .maze_in    (maze_in),
    .maze_vis   (maze_vis),
    .path_count (path_count),
    .err_wall_we(err_wall_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
  } chk_t;

  chk_t q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic string kname(int k);
    case (k)
      K_RD:    return "read{in,vis}";
      K_CNT:   return "path_count";
      K_ERR:   return "err_wall_we";
      K_LDD:   return "loaded";
      default: return "load_ready";
    endcase
  endfunction

  function automatic logic [15:0] actual(int k);
    case (k)
      K_RD:    return {14'd0, maze_in, maze_vis};
      K_CNT:   return {3'd0, path_count};
      K_ERR:   return {15'd0, err_wall_we};
      K_LDD:   return {15'd0, loaded};
      default: return {15'd0, load_ready};
    endcase
  endfunction

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    int i;
    logic [15:0] act;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due <= cyc) begin
        total = total + 1;
        act = actual(q[i].kind);
        if (q[i].due != cyc || act !== q[i].exp)
          $display("FAIL %s cycle %0d: got %0h expected %0h (due %0d)",
                   kname(q[i].kind), cyc, act, q[i].exp, q[i].due);
        else
          passed = passed + 1;
        q.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  task automatic push(input int due, input int kind, input logic [15:0] exp);
    chk_t c;
    c.due = due; c.kind = kind; c.exp = exp;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] row_pat(input int pat, input int r);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    case (pat)
      0:       return (r == 5) ? one : (one << (N - 1 - r));  // anti-diagonal
      1:       return one << r;                               // diagonal
      2:       return {N{1'b1}};
      default: return ~(one << r);                            // all walls but diagonal
    endcase
  endfunction

  // Feed n rows; in toggle mode an idle cycle (garbage data, reload pulse) precedes each row.
  task automatic load(input int pat, input int n, input bit toggle);
    for (int r = 0; r < n; r++) begin
      if (toggle) begin
        load_valid = 1'b0; load_data = {N{1'b1}}; reload = 1'b1;
        push(cyc, K_RDY, 16'd1);
        tick();
        reload = 1'b0;
      end
      load_valid = 1'b1;
      load_data  = row_pat(pat, r);
      push(cyc, K_RDY, 16'd1);
      push(cyc, K_LDD, 16'd0);
      tick();
    end
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  task automatic rd(input int r, input int c, input logic win, input logic wvis);
    row = IDX_W'(r); col = IDX_W'(c); maze_oe = 1'b1;
    push(cyc + 1, K_RD, {14'd0, win, wvis});
    tick();
    maze_oe = 1'b0;
  endtask

  task automatic wr(input int r, input int c, input int cnt, input logic err);
    row = IDX_W'(r); col = IDX_W'(c); maze_we = 1'b1;
    push(cyc + 1, K_CNT, 16'(cnt));
    push(cyc + 1, K_ERR, {15'd0, err});
    tick();
    maze_we = 1'b0;
  endtask

  task automatic expect_served();
    push(cyc, K_LDD, 16'd1);
    push(cyc, K_RDY, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; reload = 1'b0;
    row = '0; col = '0; maze_oe = 1'b0; maze_we = 1'b0;
    tick();
    push(cyc, K_RDY, 16'd1); push(cyc, K_LDD, 16'd0); push(cyc, K_RD, 16'd0);
    push(cyc, K_CNT, 16'd0); push(cyc, K_ERR, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full load with valid held high.
    load(0, N, 1'b0);
    expect_served();
    push(cyc, K_CNT, 16'd0); push(cyc, K_ERR, 16'd0);
    total = total + 1;
    if (loaded !== 1'b1 || load_ready !== 1'b0)
      $display("FAIL direct: after full load loaded=%b load_ready=%b", loaded, load_ready);
    else
      passed = passed + 1;

    // Reads: latency, hold with oe low, row ordering.
    rd(5, 0, 1'b1, 1'b0);
    total = total + 1;
    if (maze_in !== 1'b1 || maze_vis !== 1'b0)
      $display("FAIL direct: read [5,0] in=%b vis=%b", maze_in, maze_vis);
    else
      passed = passed + 1;
    row = 6'd5; col = 6'd1; push(cyc + 1, K_RD, 16'b10); tick();
    rd(5, 1, 1'b0, 1'b0);
    rd(20, 43, 1'b1, 1'b0);
    rd(20, 20, 1'b0, 1'b0);
    rd(63, 0, 1'b1, 1'b0);
    rd(0, 63, 1'b1, 1'b0);

    // Visit counting, repeated write, read+write on the same edge.
    wr(10, 10, 1, 1'b0);
    wr(10, 10, 1, 1'b0);
    wr(10, 11, 2, 1'b0);
    total = total + 1;
    if (path_count !== CNT_W'(2))
      $display("FAIL direct: path_count=%0d expected 2", path_count);
    else
      passed = passed + 1;
    row = 6'd10; col = 6'd12; maze_oe = 1'b1; maze_we = 1'b1;
    push(cyc + 1, K_RD, 16'b00); push(cyc + 1, K_CNT, 16'd3);
    tick();
    maze_oe = 1'b0; maze_we = 1'b0;
    rd(10, 12, 1'b0, 1'b1);
    rd(10, 10, 1'b0, 1'b1);

    // Write to a wall cell, then reload with an access in the same cycle.
    wr(5, 0, 3, 1'b1);
    total = total + 1;
    if (err_wall_we !== 1'b1 || path_count !== CNT_W'(3))
      $display("FAIL direct: wall write err=%b count=%0d", err_wall_we, path_count);
    else
      passed = passed + 1;
    rd(5, 0, 1'b1, 1'b0);
    reload = 1'b1; maze_oe = 1'b1; maze_we = 1'b1; row = 6'd5; col = 6'd1;
    push(cyc + 1, K_LDD, 16'd0); push(cyc + 1, K_RDY, 16'd1);
    push(cyc + 1, K_CNT, 16'd0); push(cyc + 1, K_ERR, 16'd0);
    push(cyc + 1, K_RD, 16'b10);
    tick();
    reload = 1'b0; maze_we = 1'b0;
    total = total + 1;
    if (loaded !== 1'b0 || err_wall_we !== 1'b0 || path_count !== '0)
      $display("FAIL direct: after reload loaded=%b err=%b count=%0d",
               loaded, err_wall_we, path_count);
    else
      passed = passed + 1;

    // Stalling load with reload pulses and oe held; oe must be ignored.
    row = 6'd10; col = 6'd11; maze_oe = 1'b1;
    load(1, N, 1'b1);
    maze_oe = 1'b0;
    push(cyc, K_RD, 16'b10);
    expect_served();
    push(cyc, K_CNT, 16'd0);
    rd(7, 8, 1'b0, 1'b0);
    rd(10, 11, 1'b0, 1'b0);
    rd(10, 12, 1'b0, 1'b0);
    rd(7, 7, 1'b1, 1'b0);

    // Reset after 30 rows of a new load; a complete fresh load is then needed.
    reload = 1'b1; push(cyc + 1, K_LDD, 16'd0); tick(); reload = 1'b0;
    row = 6'd40; col = 6'd41; maze_oe = 1'b1;
    load(2, 30, 1'b0);
    maze_oe = 1'b0;
    push(cyc, K_RD, 16'b10);
    tick();
    rst_n = 1'b0;
    push(cyc, K_LDD, 16'd0); push(cyc, K_RDY, 16'd1); push(cyc, K_RD, 16'b00);
    push(cyc, K_CNT, 16'd0); push(cyc, K_ERR, 16'd0);
    tick();
    total = total + 1;
    if (loaded !== 1'b0 || load_ready !== 1'b1 || maze_in !== 1'b0)
      $display("FAIL direct: in reset loaded=%b load_ready=%b maze_in=%b",
               loaded, load_ready, maze_in);
    else
      passed = passed + 1;
    rst_n = 1'b1;
    tick();
    load(3, N, 1'b0);
    expect_served();
    rd(3, 3, 1'b0, 1'b0);
    rd(3, 4, 1'b1, 1'b0);
    rd(40, 41, 1'b1, 1'b0);
    rd(40, 40, 1'b0, 1'b0);

    tick();
    tick();
    while (q.size() > 0) begin
      total = total + 1;
      $display("FAIL %s never checked (due %0d)", kname(q[0].kind), q[0].due);
      q.delete(0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
